nibble_alu_arbiter: RTL and testbench

Two-requester round-robin controller that shares a single 4-bit ALU (add/sub/and/or, multi-cycle, no handshake) between two client blocks.
- Latches the granted client's operands and opcode.
- Drives the shared ALU and holds its inputs stable for ALU_LAT cycles.
- Captures the ALU result and returns it on a shared result bus with a per-client one-cycle done pulse.
- Sits between the clients and the ALU instance; the ALU itself is external.

---
 rtl/nibble_alu_arbiter_pkg.sv | 17 +
 rtl/nibble_alu_arbiter_if.sv | 42 ++++
 rtl/nibble_alu_arbiter_rr_arb2.sv | 17 +
 rtl/nibble_alu_arbiter.sv | 88 ++++++++
 tb/tb_nibble_alu_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/nibble_alu_arbiter_pkg.sv
// Shared definitions for the nibble ALU arbiter slice.
//   - ALU opcode constants seen on op0/op1/alu_op
//   - FSM state encoding used by the arbiter top
package nibble_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_alu_arbiter_if.sv
// Bus bundle between two ALU clients, the arbiter and the shared external ALU.
//   client 0 : req0, a0, b0, op0      client 1 : req1, a1, b1, op1
//   result   : done0, done1, res_s, res_cout, res_id, busy
//   ALU side : alu_a, alu_b, alu_op (to ALU), alu_s, alu_cout (from ALU)
// Modports:
//   slave  - the arbiter (consumes requests and ALU result, drives the rest)
//   master - the environment (clients plus the ALU instance)
interface nibble_alu_arbiter_if;

  logic       req0;
  logic [3:0] a0;
  logic [3:0] b0;
  logic [1:0] op0;
  logic       req1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic [1:0] op1;

  logic       done0;
  logic       done1;
  logic [3:0] res_s;
  logic       res_cout;
  logic       res_id;
  logic       busy;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_s;
  logic       alu_cout;

  modport slave (
    input  req0, a0, b0, op0, req1, a1, b1, op1, alu_s, alu_cout,
    output done0, done1, res_s, res_cout, res_id, busy, alu_a, alu_b, alu_op
  );

  modport master (
    output req0, a0, b0, op0, req1, a1, b1, op1, alu_s, alu_cout,
    input  done0, done1, res_s, res_cout, res_id, busy, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/nibble_alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick.
//   req0, req1 : requests
//   last       : client granted most recently
//   gnt_valid  : at least one request present
//   gnt_id     : chosen client (the one that is not last when both request)
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = req0 | req1;
  assign gnt_id    = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/nibble_alu_arbiter.sv
// Shares one external multi-cycle 4-bit ALU between two clients.
// A granted client's operands are latched onto alu_a/alu_b/alu_op and held,
// the ALU result is captured after ALU_LAT cycles and returned on res_* with
// a one-cycle done pulse for the owning client.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : nibble_alu_arbiter_if.slave (clients, result bus, ALU side)
module nibble_alu_arbiter
  import nibble_alu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_alu_arbiter_if.slave         bus
);

  localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last;
  logic       gnt_id;
  logic       pick_valid;
  logic       pick_id;

  rr_arb2 u_rr_arb2 (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last      (last),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last         <= 1'b1;
      gnt_id       <= 1'b0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_op   <= '0;
      bus.res_s    <= '0;
      bus.res_cout <= 1'b0;
      bus.res_id   <= 1'b0;
      bus.done0    <= 1'b0;
      bus.done1    <= 1'b0;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            bus.alu_a  <= pick_id ? bus.a1  : bus.a0;
            bus.alu_b  <= pick_id ? bus.b1  : bus.b0;
            bus.alu_op <= pick_id ? bus.op1 : bus.op0;
            gnt_id     <= pick_id;
            last       <= pick_id;
            cnt        <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          // Capture and raise done on the same edge so the pulse and the
          // result appear together in the DONE cycle.
          if (cnt == CNT_LAST) begin
            bus.res_s    <= bus.alu_s;
            bus.res_cout <= bus.alu_cout;
            bus.res_id   <= gnt_id;
            bus.done0    <= ~gnt_id;
            bus.done1    <= gnt_id;
            state        <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_alu_arbiter.sv
module tb_nibble_alu_arbiter;
  import nibble_alu_pkg::*;

  localparam int unsigned LAT = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  nibble_alu_arbiter_if bus ();

  nibble_alu_arbiter #(.ALU_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench ALU: result valid LAT cycles after its inputs become stable
  // (LAT-1 register stages after the arbiter's own output register).
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    case (op)
      OP_ADD:  alu_fn = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu_fn = {1'b0, a} - {1'b0, b};
      OP_AND:  alu_fn = {1'b0, a & b};
      default: alu_fn = {1'b0, a | b};
    endcase
  endfunction

  logic [4:0] pipe [LAT-1];
  always_ff @(posedge clk) begin
    pipe[0] <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
    for (int unsigned i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign {bus.alu_cout, bus.alu_s} = pipe[LAT-2];

  typedef struct {
    logic       id;
    logic [3:0] s;
    logic       cout;
  } sb_t;
  sb_t sb [$];

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] s;
    logic       cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  // Result monitor: every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && (bus.done0 || bus.done1)) begin
      check("done_exclusive", {31'd0, bus.done0 & bus.done1}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none", bus.done0, bus.done1);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("done_owner", {31'd0, bus.done1}, {31'd0, e.id});
        check("res_id",     {31'd0, bus.res_id}, {31'd0, e.id});
        check("res_s",      {28'd0, bus.res_s}, {28'd0, e.s});
        check("res_cout",   {31'd0, bus.res_cout}, {31'd0, e.cout});
      end
    end
  end

  task automatic drive(input logic id, input logic r, input logic [3:0] a,
                       input logic [3:0] b, input logic [1:0] op);
    if (id) begin bus.req1 = r; bus.a1 = a; bus.b1 = b; bus.op1 = op; end
    else    begin bus.req0 = r; bus.a0 = a; bus.b0 = b; bus.op0 = op; end
  endtask

  // Counts negedges until the given client's done pulse (bounded).
  task automatic wait_done(input logic id, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? bus.done1 : bus.done0) && n < 30);
  endtask

  // Called at a negedge with the arbiter idle; that cycle is the grant cycle.
  // mode 1: change operands during WAIT; mode 2: drop req during WAIT.
  task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input logic [3:0] es, input logic ec,
                        input int mode);
    int n;
    drive(id, 1'b1, a, b, op);
    sb.push_back('{id: id, s: es, cout: ec});
    @(negedge clk);
    check("busy_g1",  {31'd0, bus.busy}, 32'd1);
    check("alu_a_g1", {28'd0, bus.alu_a}, {28'd0, a});
    check("alu_b_g1", {28'd0, bus.alu_b}, {28'd0, b});
    check("alu_op_g1", {30'd0, bus.alu_op}, {30'd0, op});
    if (mode == 1) drive(id, 1'b1, 4'd9, b, OP_AND);
    if (mode == 2) drive(id, 1'b0, a, b, op);
    wait_done(id, n);
    check("done_latency", n, LAT);
    check("busy_done", {31'd0, bus.busy}, 32'd1);
    check("alu_a_held", {28'd0, bus.alu_a}, {28'd0, a});
    check("alu_op_held", {30'd0, bus.alu_op}, {30'd0, op});
    @(negedge clk);
    drive(id, 1'b0, a, b, op);
    check("busy_after", {31'd0, bus.busy}, 32'd0);
  endtask

  function automatic logic [18:0] all_outs();
    all_outs = {bus.done0, bus.done1, bus.res_s, bus.res_cout, bus.res_id,
                bus.busy, bus.alu_a, bus.alu_b, bus.alu_op};
  endfunction

  vec_t vecs [8];

  initial begin
    int n;
    checks = 0;
    errors = 0;
    vecs[0] = '{id: 1'b0, a: 4'h3, b: 4'h4, op: OP_ADD, s: 4'h7, cout: 1'b0};
    vecs[1] = '{id: 1'b1, a: 4'h2, b: 4'h5, op: OP_SUB, s: 4'hD, cout: 1'b1};
    vecs[2] = '{id: 1'b0, a: 4'hF, b: 4'h1, op: OP_ADD, s: 4'h0, cout: 1'b1};
    vecs[3] = '{id: 1'b1, a: 4'hC, b: 4'hA, op: OP_AND, s: 4'h8, cout: 1'b0};
    vecs[4] = '{id: 1'b0, a: 4'h5, b: 4'hA, op: OP_OR,  s: 4'hF, cout: 1'b0};
    vecs[5] = '{id: 1'b1, a: 4'h7, b: 4'h7, op: OP_SUB, s: 4'h0, cout: 1'b0};
    vecs[6] = '{id: 1'b0, a: 4'h0, b: 4'h1, op: OP_SUB, s: 4'hF, cout: 1'b1};
    vecs[7] = '{id: 1'b1, a: 4'h9, b: 4'h9, op: OP_ADD, s: 4'h2, cout: 1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
    drive(1'b1, 1'b0, 4'h0, 4'h0, OP_ADD);
    repeat (3) @(negedge clk);
    check("reset_outputs", {13'd0, all_outs()}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single-client operations from the table (first entry: 3+4)
    for (int unsigned i = 0; i < 8; i++)
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].s, vecs[i].cout, 0);

    // Operand changes during WAIT are ignored
    run_op(1'b0, 4'h3, 4'h4, OP_ADD, 4'h7, 1'b0, 1);

    // Abandoned request still completes
    run_op(1'b1, 4'h6, 4'h2, OP_SUB, 4'h4, 1'b0, 2);
    repeat (2) @(negedge clk);
    check("idle_after_abandon", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of WAIT
    drive(1'b0, 1'b1, 4'h3, 4'h4, OP_ADD);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midop_reset_outputs", {13'd0, all_outs()}, 32'd0);
    drive(1'b0, 1'b0, 4'h3, 4'h4, OP_ADD);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_after_reset", {31'd0, bus.busy}, 32'd0);
    run_op(1'b1, 4'h2, 4'h5, OP_SUB, 4'hD, 1'b1, 0);

    // Simultaneous requests right after reset: client 0 wins the tie
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h1, 4'h1, OP_ADD);
    drive(1'b1, 1'b1, 4'h5, 4'hA, OP_OR);
    sb.push_back('{id: 1'b0, s: 4'h2, cout: 1'b0});
    sb.push_back('{id: 1'b1, s: 4'hF, cout: 1'b0});
    wait_done(1'b0, n);
    check("tie_done0_latency", n, LAT + 1);
    bus.req0 = 1'b0;
    wait_done(1'b1, n);
    check("tie_done1_gap", n, LAT + 2);
    bus.req1 = 1'b0;
    @(negedge clk);

    // Both clients holding req: strict alternation, one op per LAT+2 cycles
    drive(1'b0, 1'b1, 4'h1, 4'h2, OP_ADD);
    drive(1'b1, 1'b1, 4'h6, 4'h3, OP_AND);
    for (int unsigned k = 0; k < 6; k++)
      sb.push_back('{id: k[0], s: (k[0] ? 4'h2 : 4'h3), cout: 1'b0});
    wait_done(1'b0, n);
    check("rr_first_latency", n, LAT + 1);
    for (int unsigned k = 1; k < 6; k++) begin
      wait_done(k[0], n);
      check("rr_gap", n, LAT + 2);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (8) @(negedge clk);
    check("rr_idle_end", {31'd0, bus.busy}, 32'd0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
